// File: rtl/blake2_api_if.sv
// blake2_api_if: register access bus (select, write enable, word address, data, error)
interface blake2_api_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;
  modport master(output cs, we, address, write_data, input read_data, error);
  modport slave(input cs, we, address, write_data, output read_data, error);
endinterface

// File: rtl/blake2_api.sv
// blake2_api: register front-end for a blake2 core; define BLAKE2_API_BUSY_LOCK_EN to reject BLOCK/CONFIG writes while the core is busy
module blake2_api #(
  parameter int          BLOCK_WORDS  = 16,
  parameter int          DIGEST_WORDS = 8,
  parameter logic [31:0] CORE_VERSION = 32'h00010000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  blake2_api_if.slave               bus,
  output logic                      core_init,
  output logic                      core_next,
  output logic                      core_final,
  output logic [BLOCK_WORDS*32-1:0] core_block,
  output logic [7:0]                core_outlen,
  input  logic                      core_ready,
  input  logic [DIGEST_WORDS*32-1:0] core_digest,
  input  logic                      core_digest_valid
);
  localparam int BW_AW = $clog2(BLOCK_WORDS);
  localparam int DW_AW = $clog2(DIGEST_WORDS);
  localparam logic [7:0] BLOCK_END  = 8'(8'h10 + BLOCK_WORDS);
  localparam logic [7:0] DIGEST_END = 8'(8'h40 + DIGEST_WORDS);
  localparam logic [7:0] RST_OUTLEN = (DIGEST_WORDS == 8) ? 8'd32 : 8'd64;

  logic [31:0]      block_mem  [BLOCK_WORDS];
  logic [31:0]      digest_mem [DIGEST_WORDS];
  logic [7:0]       config_reg;
  logic             digest_valid_reg;
  logic             dv_q;
  logic             dv_rise;
  logic             is_block, is_digest, is_ctrl, is_config, is_ro, mapped;
  logic             busy_wr, bad, wr_ok, cmd_ok;
  logic [BW_AW-1:0] block_idx;
  logic [DW_AW-1:0] digest_idx;
  logic [31:0]      rdata;

`ifdef BLAKE2_API_BUSY_LOCK_EN
  assign busy_wr = (is_block || is_config) && !core_ready;
`else
  assign busy_wr = 1'b0;
`endif

  always_comb begin
    is_block   = bus.address >= 8'h10 && bus.address < BLOCK_END;
    is_digest  = bus.address >= 8'h40 && bus.address < DIGEST_END;
    is_ctrl    = bus.address == 8'h08;
    is_config  = bus.address == 8'h0a;
    is_ro      = bus.address <= 8'h02 || bus.address == 8'h09 || is_digest;
    mapped     = is_ro || is_ctrl || is_config || is_block;
    block_idx  = BW_AW'(bus.address - 8'h10);
    digest_idx = DW_AW'(bus.address - 8'h40);
    bad        = bus.cs && (!mapped || (bus.we && is_ro) || (!bus.we && is_ctrl) ||
                            (bus.we && is_ctrl && !core_ready) || (bus.we && busy_wr));
    wr_ok      = bus.cs && bus.we && !bad;
    cmd_ok     = wr_ok && is_ctrl;
    dv_rise    = core_digest_valid && !dv_q;
    rdata      = is_block                ? block_mem[block_idx]   :
                 is_digest               ? digest_mem[digest_idx] :
                 bus.address == 8'h00    ? 32'h626c616b           :
                 bus.address == 8'h01    ? 32'h65322020           :
                 bus.address == 8'h02    ? CORE_VERSION           :
                 bus.address == 8'h09    ? {30'b0, digest_valid_reg, core_ready} :
                 is_config               ? {24'b0, config_reg}    : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.read_data    <= '0;
      bus.error        <= 1'b0;
      core_init        <= 1'b0;
      core_next        <= 1'b0;
      core_final       <= 1'b0;
      block_mem        <= '{default: '0};
      digest_mem       <= '{default: '0};
      digest_valid_reg <= 1'b0;
      dv_q             <= 1'b0;
      config_reg       <= RST_OUTLEN;
    end else begin
      bus.error  <= bad;
      core_init  <= cmd_ok && bus.write_data[0];
      core_next  <= cmd_ok && bus.write_data[1:0] == 2'b10;
      core_final <= cmd_ok && bus.write_data[2:0] == 3'b100;
      dv_q       <= core_digest_valid;
      if (bus.cs && !bus.we) bus.read_data <= rdata;
      if (wr_ok && is_block) block_mem[block_idx] <= bus.write_data;
      if (wr_ok && is_config) config_reg <= bus.write_data[7:0];
      // capture on the rising edge only, so a core holding valid high cannot overwrite it
      if (dv_rise)
        for (int i = 0; i < DIGEST_WORDS; i++)
          digest_mem[i] <= core_digest[(DIGEST_WORDS-1-i)*32 +: 32];
      if (cmd_ok && bus.write_data[0]) digest_valid_reg <= 1'b0;
      else if (dv_rise) digest_valid_reg <= 1'b1;
    end
  end

  for (genvar g = 0; g < BLOCK_WORDS; g++)
    assign core_block[(BLOCK_WORDS-1-g)*32 +: 32] = block_mem[g];
  assign core_outlen = config_reg;
endmodule

// File: tb/tb_blake2_api.sv
// tb_blake2_api: scoreboard bench for blake2_api; expectations track BLAKE2_API_BUSY_LOCK_EN
module tb_blake2_api;
  localparam int BW = 16;
  localparam int DW = 8;
`ifdef BLAKE2_API_BUSY_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] d;
    logic        e;
    logic [2:0]  p;
  } exp_t;

  logic               tb_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               core_init, core_next, core_final;
  logic [BW*32-1:0]   core_block;
  logic [7:0]         core_outlen;
  logic               core_ready = 1'b1;
  logic [DW*32-1:0]   core_digest = '0;
  logic               core_digest_valid = 1'b0;
  exp_t               sb[$];
  int                 total = 0;
  int                 passed = 0;

  blake2_api_if bus();

  blake2_api #(.BLOCK_WORDS(BW), .DIGEST_WORDS(DW), .CORE_VERSION(32'h00010000)) dut (
    .clk(tb_clk), .reset_n(reset_n), .bus(bus),
    .core_init(core_init), .core_next(core_next), .core_final(core_final),
    .core_block(core_block), .core_outlen(core_outlen), .core_ready(core_ready),
    .core_digest(core_digest), .core_digest_valid(core_digest_valid)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", n, got, want);
  endtask

  task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] wd, input string n,
                     input logic cd, input logic [31:0] ed, input logic ee, input logic [2:0] ep);
    exp_t x;
    x.name = n; x.chk = cd; x.d = ed; x.e = ee; x.p = ep;
    sb.push_back(x);
    bus.cs = 1'b1; bus.we = w; bus.address = a; bus.write_data = wd;
    @(posedge tb_clk);
    #1 bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string n, input logic ee, input logic [2:0] ep);
    acc(1'b1, a, d, n, 1'b0, 32'h0, ee, ep);
  endtask

  task automatic rd(input logic [7:0] a, input string n, input logic [31:0] ed, input logic ee);
    acc(1'b0, a, 32'h0, n, 1'b1, ed, ee, 3'b000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // monitor: an access sampled at a posedge is checked at the following negedge
  initial begin
    logic a;
    exp_t x;
    forever begin
      @(posedge tb_clk);
      a = bus.cs;
      @(negedge tb_clk);
      if (a) begin
        if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else begin
          x = sb.pop_front();
          if (x.chk) chk({x.name, "_data"}, bus.read_data, x.d);
          chk({x.name, "_err"}, {31'b0, bus.error}, {31'b0, x.e});
          chk({x.name, "_pulse"}, {29'b0, core_init, core_next, core_final}, {29'b0, x.p});
        end
      end else begin
        chk("idle_err", {31'b0, bus.error}, 32'h0);
        chk("idle_pulse", {29'b0, core_init, core_next, core_final}, 32'h0);
      end
    end
  end

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = '0; bus.write_data = '0;
    idle(3);
    reset_n = 1'b1;
    chk("rst_outlen", {24'b0, core_outlen}, 32'd32);
    chk("rst_block", core_block[31:0] | core_block[BW*32-1 -: 32], 32'h0);
    rd(8'h00, "name0", 32'h626c616b, 1'b0);
    rd(8'h01, "name1", 32'h65322020, 1'b0);
    rd(8'h02, "version", 32'h00010000, 1'b0);
    wr(8'h08, 32'h7, "ctrl7", 1'b0, 3'b100);
    idle(1);
    rd(8'h09, "status_init", 32'h1, 1'b0);
    wr(8'h10, 32'hA5A5A5A5, "blk_first_wr", 1'b0, 3'b000);
    wr(8'h10 + BW - 1, 32'h5A5A5A5A, "blk_last_wr", 1'b0, 3'b000);
    rd(8'h10, "blk_first", 32'hA5A5A5A5, 1'b0);
    rd(8'h10 + BW - 1, "blk_last", 32'h5A5A5A5A, 1'b0);
    chk("core_block_msb", core_block[BW*32-1 -: 32], 32'hA5A5A5A5);
    chk("core_block_lsb", core_block[31:0], 32'h5A5A5A5A);
    wr(8'h10 + BW, 32'h1, "blk_past_end_wr", 1'b1, 3'b000);
    rd(8'h10 + BW, "blk_past_end_rd", 32'h0, 1'b1);
    for (int i = 0; i < DW; i++) core_digest[(DW-1-i)*32 +: 32] = 32'hD0000000 + 32'(i);
    core_digest_valid = 1'b1;
    idle(1);
    core_digest = ~core_digest;
    idle(1);
    core_digest_valid = 1'b0;
    idle(1);
    rd(8'h40, "dig_first", 32'hD0000000, 1'b0);
    rd(8'h40 + DW - 1, "dig_last", 32'hD0000000 + 32'(DW - 1), 1'b0);
    rd(8'h09, "status_dv", 32'h3, 1'b0);
    wr(8'h08, 32'h1, "ctrl_init", 1'b0, 3'b100);
    rd(8'h09, "status_cleared", 32'h1, 1'b0);
    wr(8'h08, 32'h6, "ctrl_next", 1'b0, 3'b010);
    wr(8'h08, 32'h4, "ctrl_final", 1'b0, 3'b001);
    wr(8'h08, 32'h0, "ctrl_noop", 1'b0, 3'b000);
    core_ready = 1'b0;
    wr(8'h08, 32'h2, "ctrl_busy", 1'b1, 3'b000);
    wr(8'h10, 32'h12345678, "blk_busy_wr", LOCK, 3'b000);
    rd(8'h10, "blk_busy_rd", LOCK ? 32'hA5A5A5A5 : 32'h12345678, 1'b0);
    wr(8'h0a, 32'h55, "cfg_busy_wr", LOCK, 3'b000);
    rd(8'h0a, "cfg_busy_rd", LOCK ? 32'h20 : 32'h55, 1'b0);
    rd(8'h09, "status_busy", 32'h0, 1'b0);
    core_ready = 1'b1;
    wr(8'h00, 32'hFFFFFFFF, "name0_wr", 1'b1, 3'b000);
    rd(8'h00, "name0_kept", 32'h626c616b, 1'b0);
    rd(8'h08, "ctrl_rd", 32'h0, 1'b1);
    rd(8'h03, "unmapped_rd", 32'h0, 1'b1);
    rd(8'h40 + DW, "dig_past_end_rd", 32'h0, 1'b1);
    wr(8'h40, 32'h1, "dig_wr", 1'b1, 3'b000);
    rd(8'h11, "blk_unwritten", 32'h0, 1'b0);
    wr(8'h0a, 32'hFFFFFF40, "cfg_wr", 1'b0, 3'b000);
    rd(8'h0a, "cfg_rd", 32'h40, 1'b0);
    chk("outlen", {24'b0, core_outlen}, 32'h40);
    reset_n = 1'b0;
    wr(8'h08, 32'h1, "ctrl_in_reset", 1'b0, 3'b000);
    reset_n = 1'b1;
    rd(8'h10, "blk_after_rst", 32'h0, 1'b0);
    rd(8'h0a, "cfg_after_rst", 32'h20, 1'b0);
    rd(8'h40, "dig_after_rst", 32'h0, 1'b0);
    rd(8'h09, "status_after_rst", 32'h1, 1'b0);
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/blake2_api.md
BLAKE2_API -- requirements
Module: blake2_api

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 16: message block size in 32-bit words, legal values 16 (blake2s) and 32 (blake2b).
REQ-002 SHALL have parameter DIGEST_WORDS, default 8: digest size in 32-bit words, legal values 8 and 16.
REQ-003 SHALL have parameter CORE_VERSION, default 32'h00010000: value returned by the VERSION register.
REQ-004 SHALL have ports: clk in 1, the single clock; reset_n in 1, reset, synchronous active-low.
REQ-005 SHALL have ports: cs in 1, access select; we in 1, 1 = write, 0 = read.
REQ-006 SHALL have ports: address in 8, word address; write_data in 32; read_data out 32; error out 1, access error.
REQ-007 SHALL have ports: core_init out 1, core_next out 1, core_final out 1: single-cycle command pulses to the core.
REQ-008 SHALL have ports: core_block out BLOCK_WORDS*32, word 0 in the MSBs; core_outlen out 8.
REQ-009 SHALL have ports: core_ready in 1; core_digest in DIGEST_WORDS*32, word 0 in the MSBs; core_digest_valid in 1.

Function
REQ-010 Address map SHALL be: 0x00 NAME0 = "blak" (ro), 0x01 NAME1 = "e2  " (ro), 0x02 VERSION (ro), 0x08 CTRL (wo), 0x09 STATUS (ro), 0x0A CONFIG (rw).
REQ-011 Address map SHALL continue: BLOCK at 0x10..0x10+BLOCK_WORDS-1 (rw); DIGEST at 0x40..0x40+DIGEST_WORDS-1 (ro).
REQ-012 Reads SHALL have one-cycle latency: read_data is updated on the clock edge following a cs=1, we=0 cycle and is held until the next read.
REQ-013 error SHALL be registered and asserted for exactly the cycle after any offending access, then return to 0 unless another offending access occurs.
REQ-014 Offending accesses SHALL be: a write to a ro address, a read of CTRL, or any access to an unmapped address; an offending write SHALL change no state and an offending read SHALL return 0.
REQ-015 A CTRL write SHALL issue at most one pulse on the following cycle, chosen by priority bit0 init > bit1 next > bit2 final; lower-priority bits set in the same write are ignored without error.
REQ-016 A CTRL write with core_ready=0 SHALL issue no pulse and SHALL assert error; a CTRL write with no command bit set SHALL be a no-op.
REQ-017 STATUS SHALL read as {30'b0, digest_valid_reg, core_ready}.
REQ-018 digest_valid_reg SHALL be cleared when an init pulse is issued.
REQ-019 The digest register and digest_valid_reg SHALL be captured (digest_valid_reg set) on the rising edge of core_digest_valid, not continuously.
REQ-020 CONFIG[7:0] SHALL drive core_outlen; CONFIG[31:8] SHALL read back as 0.
REQ-021 core_block SHALL reflect the BLOCK registers directly; block writes SHALL take effect the cycle after the access.
REQ-022 cs=0 SHALL cause no state change, no pulse and no error.

Reset
REQ-023 On a clk edge with reset_n=0 the block SHALL clear read_data, error, all pulses, BLOCK, DIGEST and digest_valid_reg to 0, and SHALL set CONFIG to 8'd32 when DIGEST_WORDS=8, else 8'd64.
REQ-024 A reset asserted while a command pulse is pending SHALL suppress that pulse.

Configuration
REQ-025 With BLAKE2_API_BUSY_LOCK_EN defined, writes to BLOCK or CONFIG while core_ready=0 SHALL be discarded and SHALL assert error; without it such writes SHALL take effect normally without error.

Verification
REQ-026 Reset, then read 0x00, 0x01, 0x02 -> 32'h626c616b, 32'h65322020 and CORE_VERSION, each one cycle later, error=0.
REQ-027 Write 32'h0000_0007 to CTRL with core_ready=1 -> only core_init pulses, for one cycle; STATUS bit1 reads 0.
REQ-028 Write 32'hA5A5A5A5 to 0x10 and 0x5A5A5A5A to 0x10+BLOCK_WORDS-1 -> both read back; core_block MSB word = A5A5A5A5 and LSB word = 5A5A5A5A; a write to 0x10+BLOCK_WORDS -> error for one cycle.
REQ-029 Drive a core_digest pattern and pulse core_digest_valid, then change core_digest -> DIGEST reads return the captured pattern; STATUS = 3 with core_ready=1.
REQ-030 With core_ready=0: write 2 to CTRL -> no core_next pulse, error=1 for one cycle; write to 0x10 -> error and old value kept with BLAKE2_API_BUSY_LOCK_EN, new value kept without it.
REQ-031 Write to NAME0 and read CTRL -> error each time; NAME0 is unchanged and the CTRL read returns 0.
